// File: rtl/shift_queue_mp.sv
// Multi-port collapsing issue queue: entry 0 is oldest, survivors compact toward 0 each cycle.
// Optional macro SHIFT_QUEUE_MP_DEQ_FREE_EN lets same-cycle dequeues free slots for enqueue.
module shift_queue_mp #(
    parameter int N_ENTRIES   = 8,
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENQ       = 2,
    parameter int N_DEQ       = 2,
    localparam int CTR_WIDTH  = $clog2(N_ENTRIES + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [N_ENQ-1:0]                       enq_valid,
    input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]      enq_data,
    output logic [N_ENQ-1:0]                       enq_ready,
    input  logic [N_ENTRIES-1:0]                   deq_sel,
    input  logic                                   deq_ready,
    output logic [N_DEQ-1:0]                       deq_valid,
    output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]      deq_data,
    input  logic [N_ENTRIES-1:0]                   wr_en,
    input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  wr_data,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  entry_douts,
    output logic [N_ENTRIES-1:0]                   entry_valid,
    output logic [CTR_WIDTH-1:0]                   count
);

    typedef logic [CTR_WIDTH-1:0] ctr_t;

    localparam ctr_t NE_C = ctr_t'(N_ENTRIES);
    localparam ctr_t ND_C = ctr_t'(N_DEQ);

    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] r_entries;
    ctr_t                                  r_count;

    logic [N_ENTRIES-1:0]                  w_entry_valid;
    logic [N_ENTRIES-1:0]                  w_hs;
    logic [N_ENTRIES-1:0][CTR_WIDTH-1:0]   w_hrank;
    ctr_t                                  w_hs_cnt;
    logic                                  w_fire;
    ctr_t                                  w_ndeq;
    ctr_t                                  w_free;
    logic [N_ENQ-1:0]                      w_enq_ready;
    logic [N_ENQ-1:0]                      w_acc;
    logic [N_ENQ-1:0][CTR_WIDTH-1:0]       w_arank;
    ctr_t                                  w_nenq;
    logic [N_ENTRIES-1:0]                  w_surv;
    logic [N_ENTRIES-1:0][CTR_WIDTH-1:0]   w_srank;
    ctr_t                                  w_nsurv;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] w_upd;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] w_next;
    ctr_t                                  w_count_next;

    // Thermometer occupancy mask derived from the registered count.
    always_comb begin
        w_entry_valid = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_entry_valid[i] = (ctr_t'(i) < r_count);
        end
    end

    // Honour the lowest-index valid selects, at most N_DEQ of them; rank = output lane.
    always_comb begin
        ctr_t run;
        // NOTE: every combinational output gets a default before any conditional
        // assignment, so no path leaves a value held and no latch is inferred.
        run     = '0;
        w_hs    = '0;
        w_hrank = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_hrank[i] = run;
            if (deq_sel[i] && w_entry_valid[i] && (run < ND_C)) begin
                w_hs[i] = 1'b1;
                run     = run + ctr_t'(1);
            end
        end
        w_hs_cnt = run;
    end

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        if (!flush) begin
            for (int k = 0; k < N_DEQ; k++) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (w_hs[i] && (w_hrank[i] == ctr_t'(k))) begin
                        deq_valid[k] = 1'b1;
                        deq_data[k]  = r_entries[i];
                    end
                end
            end
        end
    end

    assign w_fire = deq_ready && !flush;
    assign w_ndeq = w_fire ? w_hs_cnt : '0;

`ifdef SHIFT_QUEUE_MP_DEQ_FREE_EN
    assign w_free = NE_C - r_count + w_ndeq;
`else
    assign w_free = NE_C - r_count;
`endif

    // Accepted lanes land in lane order directly behind the compacted survivors.
    always_comb begin
        ctr_t run;
        run         = '0;
        w_enq_ready = '0;
        w_acc       = '0;
        w_arank     = '0;
        for (int j = 0; j < N_ENQ; j++) begin
            w_enq_ready[j] = !flush && (w_free > ctr_t'(j));
            w_acc[j]       = enq_valid[j] && w_enq_ready[j];
            w_arank[j]     = run;
            if (w_acc[j]) begin
                run = run + ctr_t'(1);
            end
        end
        w_nenq = run;
    end

    // Writes only touch entries that stay; the updated value then travels with compaction.
    always_comb begin
        ctr_t run;
        run     = '0;
        w_surv  = '0;
        w_srank = '0;
        w_upd   = r_entries;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_surv[i]  = w_entry_valid[i] && !(w_fire && w_hs[i]);
            w_srank[i] = run;
            if (w_surv[i]) begin
                run = run + ctr_t'(1);
                if (wr_en[i]) begin
                    w_upd[i] = wr_data[i];
                end
            end
        end
        w_nsurv = run;
    end

    always_comb begin
        w_next = '0;
        for (int d = 0; d < N_ENTRIES; d++) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (w_surv[i] && (w_srank[i] == ctr_t'(d))) begin
                    w_next[d] = w_upd[i];
                end
            end
            for (int j = 0; j < N_ENQ; j++) begin
                if (w_acc[j] && ((w_nsurv + w_arank[j]) == ctr_t'(d))) begin
                    w_next[d] = enq_data[j];
                end
            end
        end
        w_count_next = w_nsurv + w_nenq;
    end

    // rst and flush clear identically, so rst priority needs no separate branch.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is reset, not just the count, because empty slots
        // are visible on entry_douts and must read as 0.
        if (rst || flush) begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values regardless of statement order.
            r_count   <= '0;
            r_entries <= '0;
        end else begin
            r_count   <= w_count_next;
            r_entries <= w_next;
        end
    end

    assign enq_ready   = w_enq_ready;
    assign entry_douts = r_entries;
    assign entry_valid = w_entry_valid;
    assign count       = r_count;

endmodule

// File: tb/tb_shift_queue_mp.sv
// Directed self-checking bench for shift_queue_mp at N_ENTRIES=8, N_ENQ=2, N_DEQ=2.
// Build with SHIFT_QUEUE_MP_DEQ_FREE_EN defined to check the dequeue-freed-slot variant.
module tb_shift_queue_mp;

    localparam int NE = 8;
    localparam int W  = 32;
    localparam int NQ = 2;
    localparam int ND = 2;
    localparam int CW = 4;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [NQ-1:0]          enq_valid;
    logic [NQ-1:0][W-1:0]   enq_data;
    logic [NQ-1:0]          enq_ready;
    logic [NE-1:0]          deq_sel;
    logic                   deq_ready;
    logic [ND-1:0]          deq_valid;
    logic [ND-1:0][W-1:0]   deq_data;
    logic [NE-1:0]          wr_en;
    logic [NE-1:0][W-1:0]   wr_data;
    logic [NE-1:0][W-1:0]   entry_douts;
    logic [NE-1:0]          entry_valid;
    logic [CW-1:0]          count;

    int n_tests = 0;
    int n_fail  = 0;

    shift_queue_mp #(
        .N_ENTRIES  (NE),
        .ENTRY_WIDTH(W),
        .N_ENQ      (NQ),
        .N_DEQ      (ND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .deq_sel    (deq_sel),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .deq_data   (deq_data),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .entry_douts(entry_douts),
        .entry_valid(entry_valid),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enqueue lanes must be prefix-packed (no valid lane above an idle one).
    always @(posedge clk) begin
        if (!rst) begin
            assert ((enq_valid & (enq_valid + 1'b1)) == '0)
                else $error("illegal non-packed enq_valid %b", enq_valid);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        enq_valid = '0;
        enq_data  = '0;
        deq_sel   = '0;
        deq_ready = 1'b0;
        wr_en     = '0;
        wr_data   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_q(input string tag, input logic [31:0] exp [NE], input int n);
        int ev;
        ev = (1 << n) - 1;
        check({tag, ".count"}, 32'(count), n[31:0]);
        check({tag, ".entry_valid"}, 32'(entry_valid), ev[31:0]);
        for (int i = 0; i < NE; i++) begin
            check($sformatf("%s.entry%0d", tag, i), entry_douts[i], exp[i]);
        end
    endtask

    task automatic flush_q();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic load(input int n, input logic [31:0] base);
        flush_q();
        for (int i = 0; i < n; i += 2) begin
            enq_valid   = (n - i >= 2) ? 2'b11 : 2'b01;
            enq_data[0] = base + 32'(i);
            enq_data[1] = base + 32'(i + 1);
            step();
        end
        idle();
    endtask

    localparam logic [31:0] VA = 32'hAAAA_0001;
    localparam logic [31:0] VB = 32'hBBBB_0002;
    localparam logic [31:0] VC = 32'hCCCC_0003;
    localparam logic [31:0] VD = 32'hDDDD_0004;
    localparam logic [31:0] VH = 32'h4848_0005;
    localparam logic [31:0] VW = 32'h5555_0003;
    localparam logic [31:0] VX = 32'hDEAD_0001;
    localparam logic [31:0] VZ = 32'h7A7A_0005;
    localparam logic [31:0] EB = 32'hE000_0000;
    localparam logic [31:0] FB = 32'hF000_0000;
    localparam logic [31:0] GB = 32'h4700_0000;
    localparam logic [31:0] KB = 32'h2200_0000;
    localparam logic [31:0] RB = 32'h3300_0000;

    initial begin
        // Reset held with live handshakes on every input: all of it is discarded.
        idle();
        rst       = 1'b1;
        enq_valid = 2'b11;
        enq_data  = {32'h1111_1111, 32'h2222_2222};
        deq_sel   = '1;
        deq_ready = 1'b1;
        wr_en     = '1;
        step();
        step();
        rst = 1'b0;
        idle();
        settle();
        check_q("reset", '{default: 32'h0}, 0);
        check("reset.deq_valid", 32'(deq_valid), 32'h0);
        check("reset.deq_data0", deq_data[0], 32'h0);
        check("reset.enq_ready", 32'(enq_ready), 32'h3);

        // Test 1: two enqueues; same-cycle issue of a fresh entry is impossible.
        enq_valid   = 2'b11;
        enq_data[0] = VA;
        enq_data[1] = VB;
        deq_sel     = '1;
        deq_ready   = 1'b1;
        settle();
        check("t1.deq_valid_empty", 32'(deq_valid), 32'h0);
        step();
        idle();
        check_q("t1", '{VA, VB, 0, 0, 0, 0, 0, 0}, 2);

        // Test 2: full queue, two issues plus one enqueue.
        load(8, EB);
        settle();
        check_q("t2.full", '{EB+0, EB+1, EB+2, EB+3, EB+4, EB+5, EB+6, EB+7}, 8);
        check("t2.full_enq_ready", 32'(enq_ready), 32'h0);
        deq_sel     = 8'h24;
        deq_ready   = 1'b1;
        enq_valid   = 2'b01;
        enq_data[0] = VC;
        settle();
        check("t2.deq_valid", 32'(deq_valid), 32'h3);
        check("t2.lane0", deq_data[0], EB + 2);
        check("t2.lane1", deq_data[1], EB + 5);
`ifdef SHIFT_QUEUE_MP_DEQ_FREE_EN
        check("t2.enq_ready", 32'(enq_ready), 32'h3);
        step();
        idle();
        check_q("t2", '{EB+0, EB+1, EB+3, EB+4, EB+6, EB+7, VC, 0}, 7);
`else
        check("t2.enq_ready", 32'(enq_ready), 32'h0);
        step();
        idle();
        check_q("t2", '{EB+0, EB+1, EB+3, EB+4, EB+6, EB+7, 0, 0}, 6);
`endif

        // Test 3: three selects, only two lanes; surplus entry stays; enqueue same cycle.
        load(6, FB);
        deq_sel     = 8'h16;
        deq_ready   = 1'b1;
        enq_valid   = 2'b01;
        enq_data[0] = VD;
        settle();
        check("t3.deq_valid", 32'(deq_valid), 32'h3);
        check("t3.lane0", deq_data[0], FB + 1);
        check("t3.lane1", deq_data[1], FB + 2);
        check("t3.enq_ready", 32'(enq_ready), 32'h3);
        step();
        idle();
        check_q("t3", '{FB+0, FB+3, FB+4, FB+5, VD, 0, 0, 0}, 5);

        // Test 4: no deq_ready keeps state; then issue + write that follows compaction.
        load(5, GB);
        deq_sel = 8'h01;
        settle();
        check("t4.hold_deq_valid", 32'(deq_valid), 32'h1);
        check("t4.hold_lane0", deq_data[0], GB + 0);
        step();
        check_q("t4.hold", '{GB+0, GB+1, GB+2, GB+3, GB+4, 0, 0, 0}, 5);
        deq_sel    = 8'h02;
        deq_ready  = 1'b1;
        wr_en      = 8'h0A;
        wr_data[1] = VX;
        wr_data[3] = VW;
        settle();
        check("t4.deq_valid", 32'(deq_valid), 32'h1);
        check("t4.lane0_no_wr", deq_data[0], GB + 1);
        check("t4.lane1_zero", deq_data[1], 32'h0);
        step();
        idle();
        check_q("t4", '{GB+0, GB+2, VW, GB+4, 0, 0, 0, 0}, 4);

        // Test 5: flush overrides enqueue, dequeue and writes.
        enq_valid   = 2'b01;
        enq_data[0] = VH;
        step();
        idle();
        check_q("t5.pre", '{GB+0, GB+2, VW, GB+4, VH, 0, 0, 0}, 5);
        flush     = 1'b1;
        enq_valid = 2'b11;
        enq_data  = {VA, VB};
        deq_sel   = 8'h01;
        deq_ready = 1'b1;
        wr_en     = '1;
        wr_data   = '1;
        settle();
        check("t5.enq_ready", 32'(enq_ready), 32'h0);
        check("t5.deq_valid", 32'(deq_valid), 32'h0);
        check("t5.deq_data0", deq_data[0], 32'h0);
        step();
        idle();
        check_q("t5", '{default: 32'h0}, 0);

        // Test 6: select and write outside the occupied range have no effect.
        load(2, KB);
        deq_sel    = 8'h80;
        deq_ready  = 1'b1;
        wr_en      = 8'h20;
        wr_data[5] = VZ;
        settle();
        check("t6.deq_valid", 32'(deq_valid), 32'h0);
        check("t6.deq_data0", deq_data[0], 32'h0);
        step();
        idle();
        check_q("t6", '{KB+0, KB+1, 0, 0, 0, 0, 0, 0}, 2);

        // Test 7: reset mid-operation discards that cycle's handshakes.
        load(4, RB);
        rst       = 1'b1;
        enq_valid = 2'b11;
        enq_data  = {VC, VD};
        deq_sel   = 8'h0F;
        deq_ready = 1'b1;
        wr_en     = 8'h0F;
        step();
        rst = 1'b0;
        idle();
        settle();
        check_q("t7", '{default: 32'h0}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
